// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared state encoding and defaults for the conv-accumulate sequencer
package conv_pkg;

    localparam int KernelSizeDef = 9;
    localparam int InputDim      = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_LOAD_W,
        ST_STREAM,
        ST_DRAIN,
        ST_NEXT,
        ST_DONE
    } state_t;

endpackage

// File: rtl/conv_accum_sched_beat_counter.sv
// rtl/conv_accum_sched_beat_counter.sv - beat counter with clear, enable and terminal-count compare
module beat_counter #(
    parameter int Width    = 8,
    parameter bit Saturate = 1'b0
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             clear,
    input  logic             en,
    input  logic [Width-1:0] limit,
    output logic             hit
);

    logic [Width-1:0] count;

    // Saturating instances hold at all-ones so a late strobe can never wrap back to a match.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en && !(Saturate && (&count))) begin
            count <= count + Width'(1);
        end
    end

    assign hit = (count == limit);

endmodule

// File: rtl/conv_accum_sched.sv
// rtl/conv_accum_sched.sv - layer sequencer for the 4-channel conv-accumulate datapath
// Optional drain watchdog: define CONV_ACCUM_SCHED_TIMEOUT_EN.
module conv_accum_sched
    import conv_pkg::*;
#(
    parameter int KernelSize = KernelSizeDef,
    parameter int GroupWidth = 8,
    parameter int PixWidth   = 18,
    parameter int OutWidth   = 16
`ifdef CONV_ACCUM_SCHED_TIMEOUT_EN
    ,
    parameter int TimeoutCycles = 1024
`endif
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  start,
    input  logic [GroupWidth-1:0] cfg_groups,
    input  logic [PixWidth-1:0]   cfg_pixels,
    input  logic [OutWidth-1:0]   cfg_outputs,
    input  logic                  src_w_valid,
    output logic                  src_w_ready,
    input  logic                  src_d_valid,
    output logic                  src_d_ready,
    output logic                  conv_rst,
    output logic                  weight_valid,
    output logic                  data_valid,
    input  logic                  wr_en_conv,
    output logic                  acc_zero,
    output logic [GroupWidth-1:0] group_idx,
    output logic                  busy,
    output logic                  done,
    output logic                  err_timeout
);

    localparam int WcntWidth = $clog2(KernelSize + 1);

    state_t                state;
    state_t                state_nxt;
    logic [GroupWidth-1:0] groups_q;
    logic [PixWidth-1:0]   pixels_q;
    logic [OutWidth-1:0]   outputs_q;
    logic                  w_hs;
    logic                  d_hs;
    logic                  o_en;
    logic                  cnt_clear;
    logic                  w_last;
    logic                  d_last;
    logic                  o_hit;
    logic                  last_group;
    logic                  timeout_hit;

    assign w_hs       = (state == ST_LOAD_W) && src_w_valid;
    assign d_hs       = (state == ST_STREAM) && src_d_valid;
    assign o_en       = wr_en_conv && ((state == ST_LOAD_W) || (state == ST_STREAM) || (state == ST_DRAIN));
    assign cnt_clear  = (state == ST_CLEAR);
    assign last_group = (group_idx == groups_q - GroupWidth'(1));

    beat_counter #(.Width(WcntWidth)) u_wcnt (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .clear (cnt_clear),
        .en    (w_hs),
        .limit (WcntWidth'(KernelSize - 1)),
        .hit   (w_last)
    );

    beat_counter #(.Width(PixWidth)) u_dcnt (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .clear (cnt_clear),
        .en    (d_hs),
        .limit (pixels_q - PixWidth'(1)),
        .hit   (d_last)
    );

    // Writes start while pixels are still streaming, so ocnt runs from LOAD_W onward.
    beat_counter #(.Width(OutWidth), .Saturate(1'b1)) u_ocnt (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .clear (cnt_clear),
        .en    (o_en),
        .limit (outputs_q),
        .hit   (o_hit)
    );

`ifdef CONV_ACCUM_SCHED_TIMEOUT_EN
    localparam int TcntWidth = $clog2(TimeoutCycles + 1);

    logic [TcntWidth-1:0] tcnt;
    logic                 err_q;

    assign timeout_hit = (state == ST_DRAIN) && !o_hit && (tcnt == TcntWidth'(TimeoutCycles - 1));
    assign err_timeout = err_q;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            tcnt  <= '0;
            err_q <= 1'b0;
        end else begin
            tcnt <= (state == ST_DRAIN) ? tcnt + TcntWidth'(1) : '0;
            if ((state == ST_IDLE) && start) begin
                err_q <= 1'b0;
            end else if (timeout_hit) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err_timeout = 1'b0;
`endif

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start) state_nxt = ST_CLEAR;
            ST_CLEAR:  state_nxt = ST_LOAD_W;
            ST_LOAD_W: if (w_hs && w_last) state_nxt = (pixels_q == '0) ? ST_DRAIN : ST_STREAM;
            ST_STREAM: if (d_hs && d_last) state_nxt = ST_DRAIN;
            ST_DRAIN:  if (o_hit || timeout_hit) state_nxt = ST_NEXT;
            ST_NEXT:   state_nxt = last_group ? ST_DONE : ST_CLEAR;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        conv_rst     = 1'b0;
        src_w_ready  = 1'b0;
        src_d_ready  = 1'b0;
        weight_valid = 1'b0;
        data_valid   = 1'b0;
        done         = 1'b0;
        case (state)
            ST_CLEAR:  conv_rst = 1'b1;
            ST_LOAD_W: begin
                src_w_ready  = 1'b1;
                weight_valid = src_w_valid;
            end
            ST_STREAM: begin
                src_d_ready = 1'b1;
                data_valid  = src_d_valid;
            end
            ST_DONE:   done = 1'b1;
            default:   ;
        endcase
    end

    assign busy     = (state != ST_IDLE);
    assign acc_zero = busy && (group_idx == '0);

    // Zero groups is run as a single pass.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            groups_q  <= '0;
            pixels_q  <= '0;
            outputs_q <= '0;
        end else if ((state == ST_IDLE) && start) begin
            groups_q  <= (cfg_groups == '0) ? GroupWidth'(1) : cfg_groups;
            pixels_q  <= cfg_pixels;
            outputs_q <= cfg_outputs;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            group_idx <= '0;
        end else if ((state == ST_NEXT) && !last_group) begin
            group_idx <= group_idx + GroupWidth'(1);
        end else if (state == ST_DONE) begin
            group_idx <= '0;
        end
    end

endmodule

// File: tb/tb_conv_accum_sched.sv
// tb/tb_conv_accum_sched.sv - self-checking bench for conv_accum_sched
module tb_conv_accum_sched;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        start;
    logic [7:0]  cfg_groups;
    logic [17:0] cfg_pixels;
    logic [15:0] cfg_outputs;
    logic        src_w_valid;
    logic        src_w_ready;
    logic        src_d_valid;
    logic        src_d_ready;
    logic        conv_rst;
    logic        weight_valid;
    logic        data_valid;
    logic        wr_en_conv;
    logic        acc_zero;
    logic [7:0]  group_idx;
    logic        busy;
    logic        done;
    logic        err_timeout;

    int total = 0;
    int bad   = 0;

    // per-layer observations gathered by run_layer
    int n_rst, n_wv, n_dv, n_done, n_busy;
    int az_err, gi_err, wv_bad, dv_bad, extra_rdy, rdy_gap;
    int done_cyc, last_wr, data_end, err_first, err_at_done;
    bit finished;

    conv_accum_sched #(
`ifdef CONV_ACCUM_SCHED_TIMEOUT_EN
        .TimeoutCycles(32)
`endif
    ) dut (
        .Clk          (Clk),
        .Rst_n        (Rst_n),
        .start        (start),
        .cfg_groups   (cfg_groups),
        .cfg_pixels   (cfg_pixels),
        .cfg_outputs  (cfg_outputs),
        .src_w_valid  (src_w_valid),
        .src_w_ready  (src_w_ready),
        .src_d_valid  (src_d_valid),
        .src_d_ready  (src_d_ready),
        .conv_rst     (conv_rst),
        .weight_valid (weight_valid),
        .data_valid   (data_valid),
        .wr_en_conv   (wr_en_conv),
        .acc_zero     (acc_zero),
        .group_idx    (group_idx),
        .busy         (busy),
        .done         (done),
        .err_timeout  (err_timeout)
    );

    always #5 Clk = ~Clk;

    // vmode: 0 streams always valid, 1 random valids, 2 data valid toggles every cycle
    task automatic run_layer(input int g, input int p, input int o, input int wr_n,
                             input int vmode, input bit wr_late, input bit poke);
        int wr_left;
        int pass_dv;
        n_rst = 0; n_wv = 0; n_dv = 0; n_done = 0; n_busy = 0;
        az_err = 0; gi_err = 0; wv_bad = 0; dv_bad = 0; extra_rdy = 0; rdy_gap = 0;
        done_cyc = -1; last_wr = -1; data_end = -1; err_first = -1; err_at_done = -1;
        finished = 1'b0;
        wr_left = 0;
        pass_dv = 0;
        cfg_groups  = 8'(g);
        cfg_pixels  = 18'(p);
        cfg_outputs = 16'(o);
        for (int c = 0; c < 4000 && !finished; c++) begin
            @(posedge Clk);
            #1;
            start       = (c == 0) || (poke && (c % 7 == 3));
            src_w_valid = (vmode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            src_d_valid = (vmode == 1) ? 1'($urandom_range(0, 1)) :
                          (vmode == 2) ? 1'(c % 2) : 1'b1;
            wr_en_conv  = 1'b0;
            if (wr_left > 0 && (!wr_late || pass_dv >= p) &&
                ((vmode == 1) ? ($urandom_range(0, 1) == 1) : 1'b1)) begin
                wr_en_conv = 1'b1;
                wr_left--;
                last_wr = c;
            end
            @(negedge Clk);
            if (c == 1) err_first = int'(err_timeout);
            if (busy) n_busy++;
            if (conv_rst) begin
                n_rst++;
                wr_left = wr_n;
                pass_dv = 0;
            end
            if (busy && int'(group_idx) != n_rst - 1) gi_err++;
            if (acc_zero !== (busy && n_rst == 1)) az_err++;
            if (src_d_ready && pass_dv >= p) extra_rdy++;
            if (!src_d_ready && n_rst > 0 && pass_dv > 0 && pass_dv < p) rdy_gap++;
            if (weight_valid) begin
                n_wv++;
                if (!(src_w_valid && src_w_ready)) wv_bad++;
            end
            if (data_valid) begin
                n_dv++;
                pass_dv++;
                data_end = c;
                if (!(src_d_valid && src_d_ready)) dv_bad++;
            end
            if (done) begin
                n_done++;
                done_cyc = c;
                err_at_done = int'(err_timeout);
                finished = 1'b1;
            end
        end
        start = 1'b0; src_w_valid = 1'b0; src_d_valid = 1'b0; wr_en_conv = 1'b0;
        total++;
        if (!finished) begin
            bad++;
            $display("FAIL layer_timeout: done never seen (g=%0d p=%0d o=%0d), required done within 4000 cycles", g, p, o);
        end
    endtask

    task automatic check_layer(input string tag, input int g, input int p);
        int passes;
        passes = (g == 0) ? 1 : g;
        total += 6;
        if (n_rst !== passes) begin bad++; $display("FAIL %s conv_rst_count: got %0d need %0d", tag, n_rst, passes); end
        if (n_wv !== 9 * passes) begin bad++; $display("FAIL %s weight_count: got %0d need %0d", tag, n_wv, 9 * passes); end
        if (n_dv !== p * passes) begin bad++; $display("FAIL %s data_count: got %0d need %0d", tag, n_dv, p * passes); end
        if (n_done !== 1) begin bad++; $display("FAIL %s done_count: got %0d need 1", tag, n_done); end
        if (az_err + gi_err !== 0) begin bad++; $display("FAIL %s acc_zero_group_idx: got %0d bad cycles need 0", tag, az_err + gi_err); end
        if (wv_bad + dv_bad !== 0) begin bad++; $display("FAIL %s valid_without_handshake: got %0d need 0", tag, wv_bad + dv_bad); end
    endtask

    task automatic test_reset();
        logic [16:0] outs;
        Rst_n = 1'b0;
        start = 1'b0; cfg_groups = '0; cfg_pixels = '0; cfg_outputs = '0;
        src_w_valid = 1'b0; src_d_valid = 1'b0; wr_en_conv = 1'b0;
        #23;
        outs = {busy, done, conv_rst, src_w_ready, src_d_ready, weight_valid, data_valid,
                acc_zero, err_timeout, group_idx};
        total++;
        if (outs !== '0) begin bad++; $display("FAIL reset_outputs: got %h need 0", outs); end
        @(negedge Clk);
        Rst_n = 1'b1;
        repeat (2) @(negedge Clk);
        outs = {busy, done, conv_rst, src_w_ready, src_d_ready, weight_valid, data_valid,
                acc_zero, err_timeout, group_idx};
        total++;
        if (outs !== '0) begin bad++; $display("FAIL idle_outputs: got %h need 0", outs); end
    endtask

    task automatic test_single_pass();
        run_layer(1, 16, 4, 4, 0, 1'b1, 1'b0);
        check_layer("single", 1, 16);
        total += 2;
        // 4 writes land in DRAIN; ocnt reaches 4 next cycle, then NEXT, then DONE
        if (done_cyc - last_wr !== 3) begin bad++; $display("FAIL single done_latency: got %0d need 3", done_cyc - last_wr); end
        // CLEAR + 9 weights + 16 pixels + 5 drain + NEXT + DONE
        if (n_busy !== 33) begin bad++; $display("FAIL single busy_cycles: got %0d need 33", n_busy); end
    endtask

    task automatic test_multi_group();
        run_layer(3, 5, 2, 2, 1, 1'b0, 1'b0);
        check_layer("multi", 3, 5);
    endtask

    task automatic test_valid_toggle();
        run_layer(1, 8, 1, 1, 2, 1'b0, 1'b0);
        check_layer("toggle", 1, 8);
        total++;
        if (extra_rdy + rdy_gap !== 0) begin bad++; $display("FAIL toggle d_ready_window: got %0d bad cycles need 0", extra_rdy + rdy_gap); end
    endtask

    task automatic test_zero_cfg();
        run_layer(0, 0, 0, 0, 0, 1'b0, 1'b0);
        check_layer("zero", 0, 0);
        total++;
        // CLEAR + 9 weights + 1 drain + NEXT + DONE
        if (n_busy !== 13) begin bad++; $display("FAIL zero busy_cycles: got %0d need 13", n_busy); end
    endtask

    task automatic test_async_reset();
        int k;
        logic [5:0] outs;
        k = 0;
        cfg_groups = 8'd2; cfg_pixels = 18'd40; cfg_outputs = 16'd0;
        for (int c = 0; c < 200 && k < 5; c++) begin
            @(posedge Clk);
            #1;
            start = (c == 0);
            src_w_valid = 1'b1; src_d_valid = 1'b1; wr_en_conv = 1'b0;
            @(negedge Clk);
            if (data_valid) k++;
        end
        #2;
        Rst_n = 1'b0;
        #1;
        outs = {busy, src_d_ready, data_valid, conv_rst, acc_zero, |group_idx};
        total += 2;
        if (k !== 5) begin bad++; $display("FAIL areset stream_reached: got %0d beats need 5", k); end
        if (outs !== '0) begin bad++; $display("FAIL areset outputs: got %b need 000000", outs); end
        src_w_valid = 1'b0; src_d_valid = 1'b0;
        #10;
        Rst_n = 1'b1;
        run_layer(2, 3, 1, 1, 0, 1'b0, 1'b0);
        check_layer("after_reset", 2, 3);
    endtask

    task automatic test_back_to_back();
        int g, p, o;
        for (int it = 0; it < 4; it++) begin
            g = $urandom_range(1, 3);
            p = $urandom_range(0, 10);
            o = $urandom_range(0, 4);
            run_layer(g, p, o, o, 1, 1'b0, 1'b1);
            check_layer("b2b", g, p);
        end
    endtask

`ifdef CONV_ACCUM_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        run_layer(1, 4, 4, 2, 0, 1'b1, 1'b0);
        total += 3;
        if (n_done !== 1) begin bad++; $display("FAIL timeout done_count: got %0d need 1", n_done); end
        // 32 drain cycles, then NEXT, then DONE
        if (done_cyc - data_end !== 34) begin bad++; $display("FAIL timeout latency: got %0d need 34", done_cyc - data_end); end
        if (err_at_done !== 1) begin bad++; $display("FAIL timeout err_set: got %0d need 1", err_at_done); end
        run_layer(1, 2, 1, 1, 0, 1'b0, 1'b0);
        total++;
        if (err_first !== 0) begin bad++; $display("FAIL timeout err_clear_on_start: got %0d need 0", err_first); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_pass();
        test_multi_group();
        test_valid_toggle();
        test_zero_cfg();
        test_async_reset();
        test_back_to_back();
`ifdef CONV_ACCUM_SCHED_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
